// File: rtl/blk_rx_decoder.sv
// Receive-side block decoder: sync/data split, hi/lo credit accumulation, CRC error recovery, 2-entry data FIFO.
// Define BLK_RX_DECODER_STATS_EN to build the saturating statistics counters.
module blk_rx_decoder #(
  parameter int unsigned DATA_WORDS   = 7,
  parameter int unsigned WORD_W       = 64,
  parameter int unsigned VC_W         = 4,
  parameter int unsigned CRC_W        = 24,
  parameter int unsigned CREDIT_ACC_W = 12,
  parameter int unsigned CNT_W        = 16,
  parameter logic [2:0]  BTYPE_SYNC   = 3'b010,
  localparam int unsigned BLOCK_W     = WORD_W * (DATA_WORDS + 1),
  localparam int unsigned PAY_W       = DATA_WORDS * WORD_W,
  localparam int unsigned VCS_W       = DATA_WORDS * VC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_W-1:0]      blk_rx_data,
  input  logic                    blk_rx_valid,
  input  logic                    blk_crc_match,
  output logic [7:0]              rx_sync_txseq,
  output logic [7:0]              rx_sync_rxseq,
  output logic [1:0]              rx_sync_req,
  output logic                    rx_sync_ack,
  output logic                    rx_sync_valid,
  output logic                    rx_blk_received,
  output logic                    rx_blk_error,
  output logic [PAY_W-1:0]        rx_data_payload,
  output logic [VCS_W-1:0]        rx_data_vcs,
  output logic                    rx_data_ack,
  output logic                    rx_data_valid,
  input  logic                    rx_data_ready,
  output logic [CREDIT_ACC_W-1:0] credits_lo,
  output logic [CREDIT_ACC_W-1:0] credits_hi,
  input  logic                    credit_take_lo,
  input  logic                    credit_take_hi,
  output logic                    rx_overflow,
  output logic                    credit_ovf,
  output logic [CNT_W-1:0]        stat_crc_err,
  output logic [CNT_W-1:0]        stat_data_blk,
  output logic [CNT_W-1:0]        stat_drop
);

  if (CRC_W + VC_W * DATA_WORDS != 52) begin : g_crc_w_check
    $error("blk_rx_decoder: CRC_W + VC_W*DATA_WORDS must equal 52");
  end
  if (CREDIT_ACC_W < 8) begin : g_acc_w_check
    $error("blk_rx_decoder: CREDIT_ACC_W must be at least 8");
  end

  typedef enum logic {LINK_OK = 1'b0, ERR_DROP = 1'b1} state_t;

  typedef struct packed {
    logic [PAY_W-1:0] payload;
    logic [VCS_W-1:0] vcs;
    logic             ack;
  } entry_t;

  state_t                state;
  entry_t                mem0, mem1, new_entry;
  logic [1:0]            fifo_cnt;
  logic [63:0]           hdr;
  logic                  good, bad, is_data, is_sync, is_idle, good_sync;
  logic                  accept, push_req, pop, push, ovf_drop;
  logic [CREDIT_ACC_W:0] sum_lo, sum_hi;
  logic                  unused_crc;

  assign hdr        = blk_rx_data[63:0];
  assign unused_crc = ^hdr[CRC_W-1:0];

  // Block classification and acceptance
  assign good      = blk_rx_valid & blk_crc_match;
  assign bad       = blk_rx_valid & ~blk_crc_match;
  assign is_data   = ~hdr[62];
  assign is_sync   = (hdr[63:61] == BTYPE_SYNC);
  assign is_idle   = &hdr[51:CRC_W];
  assign good_sync = good & is_sync;
  assign accept    = good & is_data & (state == LINK_OK);
  assign push_req  = accept & ~is_idle;
  assign pop       = (fifo_cnt != 2'd0) & rx_data_ready;
  assign push      = push_req & ((fifo_cnt != 2'd2) | pop);
  assign ovf_drop  = push_req & ~push;

  // Reorder payload so that word 0 lands in the MSBs
  always_comb begin
    new_entry = '0;
    for (int i = 0; i < DATA_WORDS; i++) begin
      new_entry.payload[(DATA_WORDS-1-i)*WORD_W +: WORD_W] = blk_rx_data[WORD_W*(i+1) +: WORD_W];
    end
    new_entry.vcs = hdr[51:CRC_W];
    new_entry.ack = hdr[60];
  end

  assign sum_lo = (credit_take_lo ? {(CREDIT_ACC_W+1){1'b0}} : {1'b0, credits_lo})
                + ((accept & ~hdr[61]) ? (CREDIT_ACC_W+1)'(hdr[59:52]) : {(CREDIT_ACC_W+1){1'b0}});
  assign sum_hi = (credit_take_hi ? {(CREDIT_ACC_W+1){1'b0}} : {1'b0, credits_hi})
                + ((accept &  hdr[61]) ? (CREDIT_ACC_W+1)'(hdr[59:52]) : {(CREDIT_ACC_W+1){1'b0}});

  assign rx_data_payload = mem0.payload;
  assign rx_data_vcs     = mem0.vcs;
  assign rx_data_ack     = mem0.ack;
  assign rx_data_valid   = (fifo_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= LINK_OK;
      rx_sync_txseq   <= '0;
      rx_sync_rxseq   <= '0;
      rx_sync_req     <= '0;
      rx_sync_ack     <= 1'b0;
      rx_sync_valid   <= 1'b0;
      rx_blk_received <= 1'b0;
      rx_blk_error    <= 1'b0;
      credits_lo      <= '0;
      credits_hi      <= '0;
      rx_overflow     <= 1'b0;
      credit_ovf      <= 1'b0;
      mem0            <= '0;
      mem1            <= '0;
      fifo_cnt        <= 2'd0;
    end else begin
      rx_sync_valid   <= good_sync;
      rx_blk_received <= accept;
      rx_blk_error    <= bad;
      if (good_sync) begin
        rx_sync_txseq <= hdr[51:44];
        rx_sync_rxseq <= hdr[43:36];
        rx_sync_req   <= hdr[53:52];
        rx_sync_ack   <= hdr[60];
      end

      // Error recovery: only a good SYNC re-opens the link
      case (state)
        LINK_OK:  if (bad)       state <= ERR_DROP;
        ERR_DROP: if (good_sync) state <= LINK_OK;
        default:                 state <= LINK_OK;
      endcase

      credits_lo <= sum_lo[CREDIT_ACC_W] ? '1 : sum_lo[CREDIT_ACC_W-1:0];
      credits_hi <= sum_hi[CREDIT_ACC_W] ? '1 : sum_hi[CREDIT_ACC_W-1:0];
      if (sum_lo[CREDIT_ACC_W] | sum_hi[CREDIT_ACC_W]) credit_ovf <= 1'b1;
      if (ovf_drop) rx_overflow <= 1'b1;

      // Two-entry FIFO, mem0 is the head
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) mem0 <= new_entry;
          else                  mem1 <= new_entry;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          mem0     <= mem1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            mem0 <= new_entry;
          end else begin
            mem0 <= mem1;
            mem1 <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BLK_RX_DECODER_STATS_EN
  logic err_discard;
  assign err_discard = blk_rx_valid & is_data & (state == ERR_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_crc_err  <= '0;
      stat_data_blk <= '0;
      stat_drop     <= '0;
    end else begin
      if (bad && stat_crc_err != '1)                     stat_crc_err  <= stat_crc_err + CNT_W'(1);
      if (push && stat_data_blk != '1)                   stat_data_blk <= stat_data_blk + CNT_W'(1);
      if ((err_discard | ovf_drop) && stat_drop != '1)   stat_drop     <= stat_drop + CNT_W'(1);
    end
  end
`else
  assign stat_crc_err  = '0;
  assign stat_data_blk = '0;
  assign stat_drop     = '0;
`endif

endmodule

// File: tb/tb_blk_rx_decoder.sv
// Directed bench for blk_rx_decoder: reference model with per-cycle compare plus literal spot checks.
module tb_blk_rx_decoder;
  localparam int unsigned DATA_WORDS = 7;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned VC_W       = 4;
  localparam int unsigned CRC_W      = 24;
  localparam int unsigned ACC_W      = 12;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned BLOCK_W    = WORD_W * (DATA_WORDS + 1);
  localparam int unsigned PAY_W      = DATA_WORDS * WORD_W;
  localparam int unsigned VCS_W      = DATA_WORDS * VC_W;
  localparam int          ACC_MAX    = (1 << ACC_W) - 1;
  localparam logic [2:0]  SYNC_T     = 3'b010;

  logic               clk = 1'b0;
  logic               rst;
  logic [BLOCK_W-1:0] blk_rx_data;
  logic               blk_rx_valid, blk_crc_match;
  logic [7:0]         rx_sync_txseq, rx_sync_rxseq;
  logic [1:0]         rx_sync_req;
  logic               rx_sync_ack, rx_sync_valid, rx_blk_received, rx_blk_error;
  logic [PAY_W-1:0]   rx_data_payload;
  logic [VCS_W-1:0]   rx_data_vcs;
  logic               rx_data_ack, rx_data_valid, rx_data_ready;
  logic [ACC_W-1:0]   credits_lo, credits_hi;
  logic               credit_take_lo, credit_take_hi, rx_overflow, credit_ovf;
  logic [CNT_W-1:0]   stat_crc_err, stat_data_blk, stat_drop;

  blk_rx_decoder #(
    .DATA_WORDS(DATA_WORDS), .WORD_W(WORD_W), .VC_W(VC_W), .CRC_W(CRC_W),
    .CREDIT_ACC_W(ACC_W), .CNT_W(CNT_W), .BTYPE_SYNC(SYNC_T)
  ) dut (
    .clk(clk), .rst(rst), .blk_rx_data(blk_rx_data), .blk_rx_valid(blk_rx_valid),
    .blk_crc_match(blk_crc_match), .rx_sync_txseq(rx_sync_txseq), .rx_sync_rxseq(rx_sync_rxseq),
    .rx_sync_req(rx_sync_req), .rx_sync_ack(rx_sync_ack), .rx_sync_valid(rx_sync_valid),
    .rx_blk_received(rx_blk_received), .rx_blk_error(rx_blk_error),
    .rx_data_payload(rx_data_payload), .rx_data_vcs(rx_data_vcs), .rx_data_ack(rx_data_ack),
    .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .credits_lo(credits_lo), .credits_hi(credits_hi),
    .credit_take_lo(credit_take_lo), .credit_take_hi(credit_take_hi),
    .rx_overflow(rx_overflow), .credit_ovf(credit_ovf),
    .stat_crc_err(stat_crc_err), .stat_data_blk(stat_data_blk), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: queue of expected FIFO entries and integer accumulators
  typedef struct {
    logic [PAY_W-1:0] p;
    logic [VCS_W-1:0] v;
    logic             a;
  } exp_t;

  exp_t        q[$];
  bit          m_live = 0;
  bit          m_dropping, m_ovf, m_cr_ovf, m_sv, m_recv, m_err;
  int          m_lo, m_hi, lo0, hi0, m_crc_cnt, m_data_cnt, m_drop_cnt;
  logic [7:0]  m_tx, m_rx;
  logic [1:0]  m_req;
  logic        m_ack;
  logic [63:0] h;

  function automatic exp_t to_entry(input logic [BLOCK_W-1:0] b);
    exp_t e;
    for (int i = 0; i < DATA_WORDS; i++) e.p[PAY_W - WORD_W*(i+1) +: WORD_W] = b[WORD_W*(i+1) +: WORD_W];
    e.v = b[51:CRC_W];
    e.a = b[60];
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_live = 1; m_dropping = 0; m_ovf = 0; m_cr_ovf = 0;
      m_sv = 0; m_recv = 0; m_err = 0;
      m_lo = 0; m_hi = 0; m_crc_cnt = 0; m_data_cnt = 0; m_drop_cnt = 0;
      m_tx = 0; m_rx = 0; m_req = 0; m_ack = 0;
    end else begin
      h = blk_rx_data[63:0];
      m_sv = 0; m_recv = 0; m_err = 0;
      lo0 = credit_take_lo ? 0 : m_lo;
      hi0 = credit_take_hi ? 0 : m_hi;
      if (q.size() > 0 && rx_data_ready) void'(q.pop_front());
      if (blk_rx_valid) begin
        if (!blk_crc_match) begin
          m_err = 1; m_crc_cnt++;
          if (m_dropping && !h[62]) m_drop_cnt++;
          m_dropping = 1;
        end else if (h[63:61] == SYNC_T) begin
          m_sv = 1; m_dropping = 0;
          m_tx = h[51:44]; m_rx = h[43:36]; m_req = h[53:52]; m_ack = h[60];
        end else if (!h[62]) begin
          if (m_dropping) m_drop_cnt++;
          else begin
            m_recv = 1;
            if (h[61]) hi0 += int'(h[59:52]);
            else       lo0 += int'(h[59:52]);
            if (!(&h[51:CRC_W])) begin
              if (q.size() < 2) begin q.push_back(to_entry(blk_rx_data)); m_data_cnt++; end
              else begin m_ovf = 1; m_drop_cnt++; end
            end
          end
        end
      end
      if (lo0 > ACC_MAX) begin lo0 = ACC_MAX; m_cr_ovf = 1; end
      if (hi0 > ACC_MAX) begin hi0 = ACC_MAX; m_cr_ovf = 1; end
      m_lo = lo0; m_hi = hi0;
    end
  end

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("sync_valid", rx_sync_valid, m_sv);
      chk("sync_txseq", rx_sync_txseq, m_tx);
      chk("sync_rxseq", rx_sync_rxseq, m_rx);
      chk("sync_req", rx_sync_req, m_req);
      chk("sync_ack", rx_sync_ack, m_ack);
      chk("blk_received", rx_blk_received, m_recv);
      chk("blk_error", rx_blk_error, m_err);
      chk("data_valid", rx_data_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("payload", rx_data_payload, q[0].p);
        chk("vcs", rx_data_vcs, q[0].v);
        chk("data_ack", rx_data_ack, q[0].a);
      end
      chk("credits_lo", credits_lo, m_lo);
      chk("credits_hi", credits_hi, m_hi);
      chk("rx_overflow", rx_overflow, m_ovf);
      chk("credit_ovf", credit_ovf, m_cr_ovf);
`ifdef BLK_RX_DECODER_STATS_EN
      chk("stat_crc_err", stat_crc_err, m_crc_cnt);
      chk("stat_data_blk", stat_data_blk, m_data_cnt);
      chk("stat_drop", stat_drop, m_drop_cnt);
`else
      chk("stat_crc_err", stat_crc_err, 0);
      chk("stat_data_blk", stat_data_blk, 0);
      chk("stat_drop", stat_drop, 0);
`endif
    end
  end

  function automatic logic [BLOCK_W-1:0] mk_data(input logic hi, input logic ack, input logic [7:0] cr,
                                                 input logic [VCS_W-1:0] vcs, input logic [31:0] tag);
    logic [BLOCK_W-1:0] b;
    b = '0;
    b[61] = hi; b[60] = ack; b[59:52] = cr; b[51:CRC_W] = vcs; b[CRC_W-1:0] = tag[CRC_W-1:0];
    for (int i = 0; i < DATA_WORDS; i++) b[WORD_W*(i+1) +: WORD_W] = {tag, 32'(i)};
    return b;
  endfunction

  function automatic logic [BLOCK_W-1:0] mk_sync(input logic [7:0] tx, input logic [7:0] rx,
                                                 input logic [1:0] req, input logic ack);
    logic [BLOCK_W-1:0] b;
    b = '0;
    b[63:61] = SYNC_T; b[60] = ack; b[53:52] = req; b[51:44] = tx; b[43:36] = rx;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [BLOCK_W-1:0] b, input logic crc);
    blk_rx_data = b; blk_rx_valid = 1'b1; blk_crc_match = crc;
    tick();
    blk_rx_valid = 1'b0; blk_crc_match = 1'b0;
  endtask

  localparam logic [VCS_W-1:0] VCS_A  = 28'h0123456;
  localparam logic [VCS_W-1:0] VCS_ID = '1;
  logic [63:0] w;

  initial begin
    rst = 1'b1; blk_rx_data = '0; blk_rx_valid = 1'b0; blk_crc_match = 1'b0;
    rx_data_ready = 1'b1; credit_take_lo = 1'b0; credit_take_hi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data_valid", rx_data_valid, 0);
    chk("rst_credits_lo", credits_lo, 0);
    chk("rst_sync_txseq", rx_sync_txseq, 0);

    // Single good data block
    drive(mk_data(1'b0, 1'b1, 8'h05, VCS_A, 32'h0000_00D1), 1'b1);
    chk("t1_valid", rx_data_valid, 1);
    chk("t1_credits_lo", credits_lo, 5);
    chk("t1_received", rx_blk_received, 1);
    w = rx_data_payload[PAY_W-1 -: WORD_W];
    chk("t1_word0", w, 64'h0000_00D1_0000_0000);

    // Bad block, drops, then SYNC recovers
    drive(mk_data(1'b0, 1'b0, 8'h00, VCS_A, 32'h0000_00E0), 1'b0);
    chk("t2_error", rx_blk_error, 1);
    for (int i = 0; i < 3; i++) begin
      drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00E1 + 32'(i)), 1'b1);
      chk("t2_no_push", rx_data_valid, 0);
      chk("t2_no_recv", rx_blk_received, 0);
    end
    drive(mk_sync(8'h21, 8'h34, 2'b10, 1'b1), 1'b1);
    chk("t2_sync_valid", rx_sync_valid, 1);
    chk("t2_txseq", rx_sync_txseq, 8'h21);
    chk("t2_req", rx_sync_req, 2'b10);
    drive(mk_data(1'b0, 1'b0, 8'h00, VCS_A, 32'h0000_00E9), 1'b1);
    chk("t2_push", rx_data_valid, 1);
    chk("t2_credits_lo", credits_lo, 5);

    // Idle block carries hi credits only
    drive(mk_data(1'b1, 1'b0, 8'h03, VCS_ID, 32'h0000_00F0), 1'b1);
    chk("t3_no_push", rx_data_valid, 0);
    chk("t3_credits_hi", credits_hi, 3);
    chk("t3_received", rx_blk_received, 1);

    // Backpressure: third block overflows
    rx_data_ready = 1'b0;
    drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00A1), 1'b1);
    drive(mk_data(1'b0, 1'b1, 8'h01, VCS_A, 32'h0000_00A2), 1'b1);
    drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00A3), 1'b1);
    chk("t4_overflow", rx_overflow, 1);
    w = rx_data_payload[PAY_W-1 -: WORD_W];
    chk("t4_head_a1", w, 64'h0000_00A1_0000_0000);
    rx_data_ready = 1'b1;
    tick();
    w = rx_data_payload[PAY_W-1 -: WORD_W];
    chk("t4_head_a2", w, 64'h0000_00A2_0000_0000);
    chk("t4_a2_ack", rx_data_ack, 1);
    tick();
    chk("t4_empty", rx_data_valid, 0);

    // Credit saturation and take
    credit_take_lo = 1'b1; credit_take_hi = 1'b1;
    tick();
    credit_take_lo = 1'b0; credit_take_hi = 1'b0;
    chk("t5_cleared", credits_lo, 0);
    for (int i = 0; i < 16; i++) drive(mk_data(1'b0, 1'b0, 8'hFF, VCS_ID, 32'h100 + 32'(i)), 1'b1);
    drive(mk_data(1'b0, 1'b0, 8'd14, VCS_ID, 32'h200), 1'b1);
    chk("t5_4094", credits_lo, 4094);
    chk("t5_no_ovf", credit_ovf, 0);
    drive(mk_data(1'b0, 1'b0, 8'd8, VCS_ID, 32'h201), 1'b1);
    chk("t5_sat", credits_lo, 4095);
    chk("t5_ovf", credit_ovf, 1);
    credit_take_lo = 1'b1;
    drive(mk_data(1'b0, 1'b0, 8'd2, VCS_ID, 32'h202), 1'b1);
    credit_take_lo = 1'b0;
    chk("t5_take_add", credits_lo, 2);

    // Reset with FIFO full and link in error recovery
    rx_data_ready = 1'b0;
    drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00B1), 1'b1);
    drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00B2), 1'b1);
    drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00B0), 1'b0);
    rst = 1'b1;
    drive(mk_data(1'b0, 1'b0, 8'h07, VCS_A, 32'h0000_00BF), 1'b1);
    rst = 1'b0;
    chk("t6_valid", rx_data_valid, 0);
    chk("t6_credits_lo", credits_lo, 0);
    chk("t6_overflow", rx_overflow, 0);
    chk("t6_credit_ovf", credit_ovf, 0);
    chk("t6_received", rx_blk_received, 0);
    rx_data_ready = 1'b1;
    drive(mk_data(1'b0, 1'b0, 8'h01, VCS_A, 32'h0000_00B3), 1'b1);
    chk("t6_accept", rx_data_valid, 1);
    chk("t6_recv", rx_blk_received, 1);
    w = rx_data_payload[PAY_W-1 -: WORD_W];
    chk("t6_word0", w, 64'h0000_00B3_0000_0000);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
